// File: rtl/motor_drive_if.sv
`default_nettype none
// ============================================================================
// Module      : motor_drive_if
// Description : Command and wheel-drive bundle between the line-tracker
//               policy block (master) and the motor driver (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface motor_drive_if;
  logic [1:0] state;        // 00 turn_left, 01 turn_right, 10 go_straight, 11 stop
  logic       enable;       // 0 forces stop behaviour
  logic       left_pwm;
  logic       right_pwm;
  logic [1:0] left_motor;   // 10 forward, 01 reverse, 00 coast
  logic [1:0] right_motor;
  logic       settled;

  modport master (
    output state, enable,
    input  left_pwm, right_pwm, left_motor, right_motor, settled
  );

  modport slave (
    input  state, enable,
    output left_pwm, right_pwm, left_motor, right_motor, settled
  );
endinterface
`default_nettype wire

// File: rtl/motor_drive.sv
`default_nettype none
// ============================================================================
// Module      : motor_drive
// Description : Steering command to dual H-bridge driver. Debounces the
//               command, generates glitch-free PWM per wheel and ramps each
//               wheel duty towards its target once per PWM period.
//               Optional macro MOTOR_PIVOT_TURN_EN: inner wheel of a turn
//               runs in reverse, with a down / coast-hold / up sequence on
//               every direction flip.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_drive #(
  parameter int PWM_BITS    = 10,
  parameter int DUTY_FAST   = 700,
  parameter int DUTY_SLOW   = 400,
  parameter int RAMP_STEP   = 16,
  parameter int HOLD_CYCLES = 4
) (
  input  wire logic    clk,
  input  wire logic    reset,
  motor_drive_if.slave bus
);
  // Duties carry one extra bit so ramp arithmetic can never wrap.
  localparam int DW = PWM_BITS + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [1:0]          c_cmd_stop  = 2'b11;
  localparam logic [1:0]          c_dir_fwd   = 2'b10;
  localparam logic [1:0]          c_dir_coast = 2'b00;
  localparam logic [DW-1:0]       c_fast      = DW'(DUTY_FAST);
  localparam logic [DW-1:0]       c_slow      = DW'(DUTY_SLOW);
  localparam logic [DW-1:0]       c_step      = DW'(RAMP_STEP);
  localparam logic [HW-1:0]       c_hold_last = HW'(HOLD_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] c_cnt_max   = '1;

`ifdef MOTOR_PIVOT_TURN_EN
  localparam logic [1:0] c_dir_rev = 2'b01;

  typedef enum logic [1:0] {
    ST_FWD       = 2'd0,
    ST_DOWN      = 2'd1,
    ST_ZERO_HOLD = 2'd2,
    ST_REV       = 2'd3
  } wheel_st_t;
`endif

  logic [PWM_BITS-1:0] r_cnt;
  logic [1:0]          r_cand;
  logic [1:0]          r_active;
  logic [HW-1:0]       r_hold;
  logic                w_wrap;
  logic [1:0]          w_eff;
  logic                w_stop;

  assign w_wrap = (r_cnt == c_cnt_max);
  assign w_eff  = bus.enable ? r_active : c_cmd_stop;
  assign w_stop = (w_eff == c_cmd_stop);

  // Move cur one step towards tgt, snapping when within one step.
  function automatic logic [DW-1:0] f_ramp(input logic [DW-1:0] cur,
                                           input logic [DW-1:0] tgt);
    logic [DW-1:0] res;
    if (tgt > cur) res = ((tgt - cur) <= c_step) ? tgt : cur + c_step;
    else           res = ((cur - tgt) <= c_step) ? tgt : cur - c_step;
    return res;
  endfunction

  // Free-running PWM period counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= '0;
    else       r_cnt <= r_cnt + 1'b1;
  end

  // Debounce: a command must sit unchanged in the candidate register before
  // it replaces the active command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cand   <= c_cmd_stop;
      r_hold   <= '0;
      r_active <= c_cmd_stop;
    end else if (bus.state != r_cand) begin
      r_cand <= bus.state;
      r_hold <= '0;
    end else if (r_hold == c_hold_last) begin
      r_active <= r_cand;
    end else begin
      r_hold <= r_hold + 1'b1;
    end
  end

  // Wheel 0 is left, wheel 1 is right; a wheel is the inner one when the
  // command turns towards its side (turn_left = 00, turn_right = 01).
  for (genvar w = 0; w < 2; w++) begin : g_wheel
    logic [DW-1:0] r_duty;
    logic          r_pwm;
    logic [1:0]    w_motor;
    logic [DW-1:0] w_tgt;
    logic          w_inner;
    logic          w_ok;

    assign w_inner = (w_eff == 2'(w));
    assign w_ok    = (r_duty == w_tgt);

    // Target duty magnitude for the effective command.
    always_comb begin
      w_tgt = c_fast;
      if (w_stop)       w_tgt = '0;
      else if (w_inner) w_tgt = c_slow;
    end

    // Registered compare keeps the PWM output free of decode glitches.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) r_pwm <= 1'b0;
      else       r_pwm <= ({1'b0, r_cnt} < r_duty);
    end

`ifdef MOTOR_PIVOT_TURN_EN
    wheel_st_t     r_st;
    logic [1:0]    r_dir;
    logic [DW-1:0] w_down;

    assign w_down  = f_ramp(r_duty, '0);
    assign w_motor = (r_duty != '0) ? r_dir : c_dir_coast;

    // Direction FSM: a flip ramps to zero, coasts a full period, then ramps
    // up the other way, so 10 and 01 are never adjacent on the pins.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_st   <= ST_ZERO_HOLD;
        r_dir  <= c_dir_coast;
        r_duty <= '0;
      end else if (w_stop) begin
        r_st   <= ST_ZERO_HOLD;
        r_dir  <= c_dir_coast;
        r_duty <= '0;
      end else if (w_wrap) begin
        case (r_st)
          ST_ZERO_HOLD: begin
            r_duty <= f_ramp(r_duty, w_tgt);
            r_st   <= w_inner ? ST_REV : ST_FWD;
            r_dir  <= w_inner ? c_dir_rev : c_dir_fwd;
          end
          ST_FWD: begin
            if (w_inner) begin
              r_duty <= w_down;
              r_st   <= (w_down == '0) ? ST_ZERO_HOLD : ST_DOWN;
            end else begin
              r_duty <= f_ramp(r_duty, w_tgt);
            end
          end
          ST_REV: begin
            if (!w_inner) begin
              r_duty <= w_down;
              r_st   <= (w_down == '0) ? ST_ZERO_HOLD : ST_DOWN;
            end else begin
              r_duty <= f_ramp(r_duty, w_tgt);
            end
          end
          default: begin
            r_duty <= w_down;
            if (w_down == '0) begin
              r_st  <= ST_ZERO_HOLD;
              r_dir <= c_dir_coast;
            end
          end
        endcase
      end
    end
`else
    assign w_motor = (r_duty != '0) ? c_dir_fwd : c_dir_coast;

    // Duty ramp: stop clears at once, otherwise step only at period wrap.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_duty <= '0;
      else if (w_stop) r_duty <= '0;
      else if (w_wrap) r_duty <= f_ramp(r_duty, w_tgt);
    end
`endif
  end

  assign bus.left_pwm    = g_wheel[0].r_pwm;
  assign bus.right_pwm   = g_wheel[1].r_pwm;
  assign bus.left_motor  = g_wheel[0].w_motor;
  assign bus.right_motor = g_wheel[1].w_motor;
  assign bus.settled     = g_wheel[0].w_ok & g_wheel[1].w_ok;
endmodule
`default_nettype wire

// File: tb/tb_motor_drive.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_drive
// Description : Self-checking bench for motor_drive with a behavioural
//               per-cycle model and directed stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_drive;
  localparam int PB = 4, FAST = 12, SLOW = 6, STEP = 4, HOLD = 3;
  localparam int PER = 16;

  logic clk = 1'b0;
  logic reset;
  logic cmp_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  motor_drive_if bus();

  motor_drive #(
    .PWM_BITS(PB), .DUTY_FAST(FAST), .DUTY_SLOW(SLOW),
    .RAMP_STEP(STEP), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
`ifdef MOTOR_PIVOT_TURN_EN
  localparam bit PIVOT = 1'b1;
`else
  localparam bit PIVOT = 1'b0;
`endif

  int         m_cnt = 0;
  int         m_duty [2] = '{0, 0};
  int         m_dir  [2] = '{1, 1};   // +1 forward, -1 reverse
  logic       m_pwm  [2] = '{1'b0, 1'b0};
  logic [1:0] m_hist [HOLD+1];
  logic [1:0] m_active = 2'b11;
  logic [1:0] m_eff;
  int         m_d, m_t;
  bit         m_same;

  function automatic int ramp(input int cur, input int tgt);
    if (tgt - cur > STEP) return cur + STEP;
    if (cur - tgt > STEP) return cur - STEP;
    return tgt;
  endfunction

  function automatic int tgt_mag(input logic [1:0] cmd, input int w);
    if (cmd == 2'b11) return 0;
    if (cmd == 2'b10) return FAST;
    return (int'(cmd) == w) ? SLOW : FAST;
  endfunction

  function automatic int tgt_dir(input logic [1:0] cmd, input int w);
    if (PIVOT && cmd != 2'b11 && cmd != 2'b10 && int'(cmd) == w) return -1;
    return 1;
  endfunction

  function automatic logic [1:0] exp_motor(input int duty, input int dir);
    if (duty == 0) return 2'b00;
    return (dir > 0) ? 2'b10 : 2'b01;
  endfunction

  // Model advances on the same edges as the design; inputs are stable here.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0;
      m_active = 2'b11;
      for (int w = 0; w < 2; w++) begin
        m_duty[w] = 0; m_dir[w] = 1; m_pwm[w] = 1'b0;
      end
      for (int i = 0; i <= HOLD; i++) m_hist[i] = 2'b11;
    end else begin
      m_eff = bus.enable ? m_active : 2'b11;
      for (int w = 0; w < 2; w++) m_pwm[w] = (m_cnt < m_duty[w]);
      for (int w = 0; w < 2; w++) begin
        if (m_eff == 2'b11) begin
          m_duty[w] = 0;
        end else if (m_cnt == PER - 1) begin
          m_d = tgt_dir(m_eff, w);
          m_t = tgt_mag(m_eff, w);
          if (m_duty[w] > 0 && m_dir[w] != m_d) begin
            m_duty[w] = ramp(m_duty[w], 0);
          end else begin
            if (m_duty[w] == 0) m_dir[w] = m_d;
            m_duty[w] = ramp(m_duty[w], m_t);
          end
        end
      end
      m_cnt = (m_cnt + 1) % PER;
      // A command is accepted once the last HOLD+1 samples agree.
      for (int i = HOLD; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = bus.state;
      m_same = 1'b1;
      for (int i = 1; i <= HOLD; i++) if (m_hist[i] != m_hist[0]) m_same = 1'b0;
      if (m_same) m_active = m_hist[0];
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [1:0] prev_lm = 2'b00, prev_rm = 2'b00;
  logic [1:0] c_eff;
  always @(negedge clk) begin
    if (cmp_en) begin
      c_eff = bus.enable ? m_active : 2'b11;
      check("left_pwm",    int'(bus.left_pwm),    int'(m_pwm[0]));
      check("right_pwm",   int'(bus.right_pwm),   int'(m_pwm[1]));
      check("left_motor",  int'(bus.left_motor),  int'(exp_motor(m_duty[0], m_dir[0])));
      check("right_motor", int'(bus.right_motor), int'(exp_motor(m_duty[1], m_dir[1])));
      check("settled", int'(bus.settled),
            int'(m_duty[0] == tgt_mag(c_eff, 0) && m_duty[1] == tgt_mag(c_eff, 1)));
      check("left_dir_flip",
            int'((prev_lm == 2'b10 && bus.left_motor == 2'b01) ||
                 (prev_lm == 2'b01 && bus.left_motor == 2'b10)), 0);
      check("right_dir_flip",
            int'((prev_rm == 2'b10 && bus.right_motor == 2'b01) ||
                 (prev_rm == 2'b01 && bus.right_motor == 2'b10)), 0);
      prev_lm = bus.left_motor;
      prev_rm = bus.right_motor;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic count_high(output int l, output int r);
    l = 0; r = 0;
    repeat (PER) begin
      @(negedge clk);
      l += int'(bus.left_pwm);
      r += int'(bus.right_pwm);
    end
    step(1);
  endtask

  task automatic wait_left_duty(input int d);
    int k = 0;
    while (m_duty[0] != d && k < 200) begin
      step(1);
      k++;
    end
    if (k >= 200) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_left_duty_%0d timeout", d);
    end
  endtask

  int l_hi, r_hi;

  initial begin
    bus.state  = 2'b11;
    bus.enable = 1'b1;
    reset      = 1'b0;
    #1 reset = 1'b1;
    step(3);
    check("rst_left_pwm",    int'(bus.left_pwm),    0);
    check("rst_right_pwm",   int'(bus.right_pwm),   0);
    check("rst_left_motor",  int'(bus.left_motor),  0);
    check("rst_right_motor", int'(bus.right_motor), 0);
    check("rst_settled",     int'(bus.settled),     1);
    cmp_en = 1'b1;
    reset  = 1'b0;

    // Straight: ramp to 12, then 12 of 16 high.
    bus.state = 2'b10;
    step(6 * PER);
    count_high(l_hi, r_hi);
    check("straight_left_high",  l_hi, 12);
    check("straight_right_high", r_hi, 12);
    check("straight_left_motor", int'(bus.left_motor), 2);
    check("straight_settled",    int'(bus.settled), 1);

    // Asynchronous reset while a PWM pulse is high.
    begin
      int k = 0;
      @(negedge clk);
      while (!bus.left_pwm && k < 40) begin @(negedge clk); k++; end
      if (k >= 40) begin
        n_checks++; n_errors++;
        $display("FAIL wait_pwm_high timeout");
      end
    end
    #2 reset = 1'b1;
    #1;
    check("async_left_pwm",    int'(bus.left_pwm),    0);
    check("async_right_pwm",   int'(bus.right_pwm),   0);
    check("async_left_motor",  int'(bus.left_motor),  0);
    check("async_right_motor", int'(bus.right_motor), 0);
    step(2);
    reset = 1'b0;
    #1;
    check("post_rst_settled",    int'(bus.settled),    1);
    check("post_rst_left_motor", int'(bus.left_motor), 0);
    step(6 * PER);

    // Short glitch on the command must be ignored.
    bus.state = 2'b00;
    step(2);
    bus.state = 2'b10;
    step(3 * PER);
    count_high(l_hi, r_hi);
    check("glitch_left_high", l_hi, 12);

    // Held turn_left: left 12 -> 8 -> 6, right stays 12.
    bus.state = 2'b00;
    step(6 * PER);
    count_high(l_hi, r_hi);
`ifdef MOTOR_PIVOT_TURN_EN
    check("turn_left_motor", int'(bus.left_motor), 1);
`else
    check("turn_left_motor", int'(bus.left_motor), 2);
`endif
    check("turn_left_high",  l_hi, 6);
    check("turn_right_high", r_hi, 12);
    check("turn_settled",    int'(bus.settled), 1);

    // Stop command mid-ramp.
    bus.state = 2'b11;
    step(3 * PER);
    bus.state = 2'b10;
    wait_left_duty(8);
    bus.state = 2'b11;
    step(7);
    check("stop_left_pwm",    int'(bus.left_pwm),    0);
    check("stop_right_pwm",   int'(bus.right_pwm),   0);
    check("stop_left_motor",  int'(bus.left_motor),  0);

    // enable drop mid-ramp.
    bus.state = 2'b10;
    step(2 * PER);
    wait_left_duty(8);
    bus.enable = 1'b0;
    step(2);
    check("en_left_pwm",     int'(bus.left_pwm),    0);
    check("en_right_motor",  int'(bus.right_motor), 0);
    check("en_settled",      int'(bus.settled),     1);
    bus.enable = 1'b1;

    // Straight again, then turn_right.
    step(6 * PER);
    bus.state = 2'b01;
    step(8 * PER);
    count_high(l_hi, r_hi);
    check("tr_left_high",  l_hi, 12);
    check("tr_right_high", r_hi, 6);
`ifdef MOTOR_PIVOT_TURN_EN
    check("tr_right_motor", int'(bus.right_motor), 1);
`else
    check("tr_right_motor", int'(bus.right_motor), 2);
`endif

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
